tx_prbs_upsampler: RTL
======================

Name: tx_prbs_upsampler

Overview:
- Transmit-side symbol source that feeds the QPSK pulse-shaping FIR.
- Generates independent PRBS9 bit streams for I and Q and maps each bit to a signed S(NB_OUTPUT,NBF_OUTPUT) symbol of ±AMPLITUDE.
- Upsamples by OS with zero-stuffing and issues one-cycle sample strobes.
- o_symb_I, o_symb_Q and o_valid connect directly to the FIR sample inputs and valid input; o_bit_I and o_bit_Q serve as the BER reference.

Parameters:
- NB_OUTPUT, 8, total output bits, signed.
- NBF_OUTPUT, 7, fractional output bits.
- AMPLITUDE, 64, positive symbol magnitude in output LSBs (64 = 0.5); must be 1..2^(NB_OUTPUT-1)-1.
- OS, 4, oversampling factor; ≥1.
- CLK_DIV, 1, clock cycles per sample tick; ≥1.
- SEED_I, 9'h1AA, I PRBS9 seed; nonzero.
- SEED_Q, 9'h1FE, Q PRBS9 seed; nonzero.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  run enable; low freezes all state.
- o_symb_I  out  NB_OUTPUT  I sample, signed S(8,7).
- o_symb_Q  out  NB_OUTPUT  Q sample, signed S(8,7).
- o_valid  out  1  one-cycle strobe; samples valid while high.
- o_bit_I  out  1  I PRBS bit of the current symbol.
- o_bit_Q  out  1  Q PRBS bit of the current symbol.
- o_phase  out  $clog2(OS) (min 1)  upsampling phase of the current sample; 0 = symbol phase.

Behaviour:
- Reset (async, active-high):
  - tick counter = 0, phase counter = 0, PRBS_I = SEED_I, PRBS_Q = SEED_Q.
  - All outputs 0, including o_valid.
  - Applies immediately mid-operation; the first strobe after reset release is a fresh phase-0 symbol from the seeds.
- Tick counter:
  - Counts 0..CLK_DIV-1 while i_enable = 1.
  - tick = i_enable & (count == CLK_DIV-1); wraps to 0 on tick.
  - CLK_DIV = 1 gives a tick on every enabled cycle.
- Phase counter:
  - Advances on tick, 0..OS-1, wraps to 0.
  - Sample emitted on a tick uses the pre-increment phase value.
- PRBS9, polynomial x^9+x^5+1, one per lane:
  - Current bit b = reg[8].
  - On a tick with phase == 0: reg <= {reg[7:0], reg[8]^reg[4]}.
  - Lane period is 511 symbols.
  - If reg is ever all-zero, it reloads its seed on the next cycle.
- Mapping (phase 0 tick only):
  - b = 0 -> +AMPLITUDE; b = 1 -> -AMPLITUDE (two's complement).
  - o_bit_* <= b.
- Zero-stuffing (phase ≠ 0 tick): o_symb_I and o_symb_Q = 0; o_bit_* hold their values.
- Latency and strobe:
  - All outputs are registered; o_valid, samples and o_phase update in the cycle after the tick condition is sampled.
  - o_valid = 1 for exactly one cycle per tick; 0 otherwise.
  - Samples hold their values between strobes.
- i_enable low:
  - Counters and PRBS frozen; o_valid = 0 from the next cycle; samples hold.
  - On re-enable, the sequence continues exactly where it stopped; no symbol is skipped or repeated.
- Output rate: OS = 1 gives a symbol on every tick with no stuffing; one symbol per OS*CLK_DIV enabled cycles.
- Compatibility: ±AMPLITUDE never hits -1.0, so the downstream FIR sees symmetric symbols.

Test Plan:
- Reset then i_enable = 1 (OS = 4, CLK_DIV = 1):
  - o_valid high every cycle from cycle 1.
  - o_phase follows 0,1,2,3,0,…
  - I samples: C0,00,00,00,C0,00,00,00,40,…
  - o_bit_I follows 1,1,0.
- Q lane, seed 9'h1FE: first symbol -64 (8'hC0).
- Run 511*OS ticks: the I and Q sequences repeat exactly; bit count over one period is 256 ones and 255 zeros.
- CLK_DIV = 3:
  - o_valid pulses 1 cycle in 3.
  - Samples are stable for the two intervening cycles.
  - Sample values match the CLK_DIV = 1 run.
- Deassert i_enable for 10 cycles mid-stream (at phase 2):
  - o_valid = 0 and outputs frozen during the gap.
  - On resume, phase 3 is emitted next and the sequence matches the uninterrupted reference.
- Assert i_reset asynchronously between clock edges mid-stream:
  - Outputs go to 0 immediately.
  - After release, the sequence restarts at C0 with phase 0.

Source files
------------

// File: rtl/tx_prbs_upsampler.sv
// PRBS9 QPSK symbol source with zero-stuffed upsampling by OS and a CLK_DIV tick divider.
// One lane per quadrature branch; each lane owns its LFSR and registered symbol/bit outputs.

module tx_prbs_lane #(
    parameter int         NB_OUTPUT = 8,
    parameter int         AMPLITUDE = 64,
    parameter logic [8:0] SEED      = 9'h1AA
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_tick,
    input  logic                        i_symbol,
    output logic signed [NB_OUTPUT-1:0] o_symb,
    output logic                        o_bit
);

    localparam logic signed [NB_OUTPUT-1:0] POS = NB_OUTPUT'(AMPLITUDE);
    localparam logic signed [NB_OUTPUT-1:0] NEG = -POS;

    logic [8:0] prbs;

    // x^9+x^5+1; an all-zero register is a lock-up state, so recover to the seed
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            prbs <= SEED;
        end else if (prbs == 9'd0) begin
            prbs <= SEED;
        end else if (i_tick && i_symbol) begin
            prbs <= {prbs[7:0], prbs[8] ^ prbs[4]};
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_symb <= '0;
            o_bit  <= 1'b0;
        end else if (i_tick) begin
            if (i_symbol) begin
                o_symb <= prbs[8] ? NEG : POS;
                o_bit  <= prbs[8];
            end else begin
                o_symb <= '0;
            end
        end
    end

endmodule

module tx_prbs_upsampler #(
    parameter int         NB_OUTPUT  = 8,
    parameter int         NBF_OUTPUT = 7,
    parameter int         AMPLITUDE  = 64,
    parameter int         OS         = 4,
    parameter int         CLK_DIV    = 1,
    parameter logic [8:0] SEED_I     = 9'h1AA,
    parameter logic [8:0] SEED_Q     = 9'h1FE,
    localparam int        PW         = (OS > 1) ? $clog2(OS) : 1
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    output logic signed [NB_OUTPUT-1:0] o_symb_I,
    output logic signed [NB_OUTPUT-1:0] o_symb_Q,
    output logic                        o_valid,
    output logic                        o_bit_I,
    output logic                        o_bit_Q,
    output logic [PW-1:0]               o_phase
);

    localparam int NUM_LANES = 2;
    localparam int CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [NUM_LANES-1:0][8:0] SEEDS = {SEED_Q, SEED_I};

    if (AMPLITUDE < 1 || AMPLITUDE > 2**(NB_OUTPUT-1) - 1) begin : g_bad_amplitude
        $error("AMPLITUDE out of range for NB_OUTPUT");
    end
    if (OS < 1 || CLK_DIV < 1) begin : g_bad_rate
        $error("OS and CLK_DIV must be at least 1");
    end
    if (NBF_OUTPUT >= NB_OUTPUT) begin : g_bad_format
        $error("NBF_OUTPUT must leave a sign bit");
    end
    if (SEED_I == 9'd0 || SEED_Q == 9'd0) begin : g_bad_seed
        $error("PRBS seeds must be nonzero");
    end

    logic [CW-1:0] tick_cnt;
    logic [PW-1:0] phase;
    logic          tick;
    logic          symbol_phase;

    logic [NUM_LANES-1:0][NB_OUTPUT-1:0] lane_symb;
    logic [NUM_LANES-1:0]                lane_bit;

    assign tick         = i_enable && (tick_cnt == CW'(CLK_DIV - 1));
    assign symbol_phase = (phase == '0);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tick_cnt <= '0;
        end else if (i_enable) begin
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            phase <= '0;
        end else if (tick) begin
            phase <= (phase == PW'(OS - 1)) ? '0 : phase + PW'(1);
        end
    end

    // Strobe and phase tag are registered alongside the lane samples so they stay aligned
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_phase <= '0;
        end else begin
            o_valid <= tick;
            if (tick) begin
                o_phase <= phase;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        tx_prbs_lane #(
            .NB_OUTPUT (NB_OUTPUT),
            .AMPLITUDE (AMPLITUDE),
            .SEED      (SEEDS[g])
        ) u_lane (
            .i_clock  (i_clock),
            .i_reset  (i_reset),
            .i_tick   (tick),
            .i_symbol (symbol_phase),
            .o_symb   (lane_symb[g]),
            .o_bit    (lane_bit[g])
        );
    end

    assign o_symb_I = lane_symb[0];
    assign o_symb_Q = lane_symb[1];
    assign o_bit_I  = lane_bit[0];
    assign o_bit_Q  = lane_bit[1];

endmodule
